fmap_streamer: RTL and testbench

FMAP_STREAMER -- requirements
Module: fmap_streamer

---
 rtl/fmap_streamer.sv | 121 ++++++++++++
 tb/tb_fmap_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_streamer.sv
// Streams a captured ROWS x COLS x CH feature map one element per transfer over a
// valid/ready port, with each element requantized by shift-and-saturate to OUT_W bits.
module fmap_streamer #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int CH    = 64,
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int SHIFT = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         src_done,
  input  logic [ROWS*COLS*CH*IN_W-1:0] src_img,
  input  logic                         m_ready,
  output logic                         m_valid,
  output logic [OUT_W-1:0]             m_data,
  output logic [IN_W-1:0]              m_raw,
  output logic                         m_last,
  output logic                         busy,
  output logic [15:0]                  sat_count
);

  localparam int N  = ROWS * COLS * CH;
  localparam int DW = (N > 1) ? $clog2(N) : 1;
  localparam int EW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

  localparam int                     MAX_I  = 2 ** (OUT_W - 1) - 1;
  localparam logic signed [EW-1:0]   MAX_V  = EW'(MAX_I);
  localparam logic signed [EW-1:0]   MIN_V  = EW'(-MAX_I - 1);
  localparam logic        [DW-1:0]   LAST_D = DW'(N - 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_LOW} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     idx_q, idx_d;
  logic [15:0]       sat_q, sat_d;
  logic [IN_W-1:0]   frame_q [N];
  logic              capture;

  logic signed [IN_W-1:0] raw_sel;
  logic signed [IN_W-1:0] shifted;
  logic signed [EW-1:0]   wide;
  logic                   sat_hi, sat_lo, sat_elem;
  logic [OUT_W-1:0]       data_sel;

  // Requantize the element currently addressed: floor shift, then clamp.
  always_comb begin
    raw_sel  = frame_q[idx_q];
    shifted  = raw_sel >>> SHIFT;
    wide     = {{(EW-IN_W){shifted[IN_W-1]}}, shifted};
    sat_hi   = wide > MAX_V;
    sat_lo   = wide < MIN_V;
    sat_elem = sat_hi | sat_lo;
    if (sat_hi)      data_sel = MAX_V[OUT_W-1:0];
    else if (sat_lo) data_sel = MIN_V[OUT_W-1:0];
    else             data_sel = wide[OUT_W-1:0];
  end

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sat_d   = sat_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (src_done) begin
          capture = 1'b1;
          idx_d   = '0;
          sat_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (m_ready) begin
          if (sat_elem && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
          if (idx_q == LAST_D) begin
            idx_d   = '0;
            state_d = src_done ? WAIT_LOW : IDLE;
          end else begin
            idx_d = idx_q + DW'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (!src_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
    end
  end

  // NOTE: the frame buffer has no reset; its contents are only observed after a capture overwrites them.
  always_ff @(posedge clock) begin
    if (capture) begin
      for (int i = 0; i < N; i++) frame_q[i] <= src_img[i*IN_W +: IN_W];
    end
  end

  // Outputs are gated by state so reset clears them without waiting for a clock.
  assign m_valid   = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign m_raw     = m_valid ? raw_sel : '0;
  assign m_data    = m_valid ? data_sel : '0;
  assign m_last    = m_valid && (idx_q == LAST_D);
  assign sat_count = sat_q;

endmodule

// File: tb/tb_fmap_streamer.sv
// Scoreboard bench for fmap_streamer: stimulus pushes expected elements, a negedge monitor
// pops and compares each transfer and checks stability under backpressure.
module tb_fmap_streamer;

  localparam int ROWS = 5, COLS = 5, CH = 64, IN_W = 12, OUT_W = 8;
  localparam int N  = ROWS * COLS * CH;
  localparam int N2 = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 src_done = 1'b0;
  logic [N*IN_W-1:0]    src_img = '0;
  logic                 m_ready = 1'b0;
  logic                 m_valid, m_last, busy;
  logic [OUT_W-1:0]     m_data;
  logic [IN_W-1:0]      m_raw;
  logic [15:0]          sat_count;

  logic                 src_done2 = 1'b0;
  logic [N2*IN_W-1:0]   src_img2 = '0;
  logic                 m_ready2 = 1'b0;
  logic                 m_valid2, m_last2, busy2;
  logic [OUT_W-1:0]     m_data2;
  logic [IN_W-1:0]      m_raw2;
  logic [15:0]          sat_count2;

  fmap_streamer #(.ROWS(ROWS), .COLS(COLS), .CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0)) dut (
    .clock(clock), .reset(reset), .src_done(src_done), .src_img(src_img), .m_ready(m_ready),
    .m_valid(m_valid), .m_data(m_data), .m_raw(m_raw), .m_last(m_last), .busy(busy),
    .sat_count(sat_count)
  );

  fmap_streamer #(.ROWS(1), .COLS(1), .CH(N2), .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(4)) dut_s4 (
    .clock(clock), .reset(reset), .src_done(src_done2), .src_img(src_img2), .m_ready(m_ready2),
    .m_valid(m_valid2), .m_data(m_data2), .m_raw(m_raw2), .m_last(m_last2), .busy(busy2),
    .sat_count(sat_count2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [IN_W-1:0]  raw;
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   model [N];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfer_cnt = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: floor(raw / 2^shift) clamped to the signed OUT_W range.
  function automatic int ref_data(input int raw, input int shift, output bit sat);
    int div, q, hi, lo;
    div = 1 << shift;
    q   = raw / div;
    if (raw < 0 && (raw % div) != 0) q = q - 1;
    hi  = (1 << (OUT_W - 1)) - 1;
    lo  = -(1 << (OUT_W - 1));
    sat = (q > hi) || (q < lo);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic load_frame(output int nsat);
    int v;
    bit s;
    exp_t e;
    nsat = 0;
    for (int d = 0; d < N; d++) begin
      v = ref_data(model[d], 0, s);
      if (s) nsat++;
      src_img[d*IN_W +: IN_W] = IN_W'(model[d]);
      e.raw  = IN_W'(model[d]);
      e.data = OUT_W'(v);
      e.last = (d == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 just after the capture edge.
  task automatic capture_frame(output int nsat);
    load_frame(nsat);
    xfer_cnt = 0;
    src_done = 1'b1;
    @(posedge clock); #1;
    check("valid_after_capture", {31'd0, m_valid}, 32'd1);
    check("busy_after_capture", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_frame_end(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clock); #1;
      cyc++;
      if (!busy) break;
    end
    check("frame_end_busy", {31'd0, busy}, 32'd0);
    check("frame_end_valid", {31'd0, m_valid}, 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clock); #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare each completed transfer and hold outputs steady through stalls.
  bit               prev_stall = 1'b0;
  logic [OUT_W-1:0] prev_data;
  logic [IN_W-1:0]  prev_raw;
  logic             prev_last;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        check("stall_raw", {20'd0, m_raw}, {20'd0, prev_raw});
        check("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("m_raw", {20'd0, m_raw}, {20'd0, e.raw});
          check("m_data", {24'd0, m_data}, {24'd0, e.data});
          check("m_last", {31'd0, m_last}, {31'd0, e.last});
        end
        xfer_cnt++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_raw   = m_raw;
      prev_last  = m_last;
    end
  end

  initial begin
    int nsat, cyc;
    int m2 [N2];
    int v;
    bit s;
    int nsat2;

    #2;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_last", {31'd0, m_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_data", {24'd0, m_data}, 32'd0);
    check("rst_raw", {20'd0, m_raw}, 32'd0);
    check("rst_sat", {16'd0, sat_count}, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Full frame, continuous ready.
    for (int d = 0; d < N; d++) model[d] = d % 100;
    capture_frame(nsat);
    src_done = 1'b0;
    wait_frame_end(cyc);
    check("t1_cycles", cyc, N);
    check("t1_xfers", xfer_cnt, N);
    check("t1_sat", {16'd0, sat_count}, nsat);
    check("t1_queue_empty", exp_q.size(), 0);

    // Same frame under random backpressure.
    rand_ready = 1'b1;
    capture_frame(nsat);
    src_done = 1'b0;
    wait_frame_end(cyc);
    check("t2_xfers", xfer_cnt, N);
    check("t2_queue_empty", exp_q.size(), 0);
    rand_ready = 1'b0;
    @(posedge clock); #1;

    // Saturation corners.
    for (int d = 0; d < N; d++) model[d] = d % 50;
    model[0] = 2047; model[1] = -2048; model[2] = 127;
    model[3] = 256;  model[4] = -200;  model[5] = 2047;
    capture_frame(nsat);
    src_done = 1'b0;
    wait_frame_end(cyc);
    check("t3_sat_count", {16'd0, sat_count}, nsat);
    check("t3_sat_five", {16'd0, sat_count}, 32'd5);
    repeat (3) @(posedge clock); #1;
    check("t3_sat_held", {16'd0, sat_count}, 32'd5);

    // src_done held high across frame end: no re-capture until it drops.
    for (int d = 0; d < N; d++) model[d] = int'($urandom_range(0, 4095)) - 2048;
    capture_frame(nsat);
    wait_frame_end(cyc);
    repeat (10) @(posedge clock); #1;
    check("t4_no_second_valid", {31'd0, m_valid}, 32'd0);
    check("t4_no_second_busy", {31'd0, busy}, 32'd0);
    check("t4_xfers", xfer_cnt, N);
    for (int d = 0; d < N; d++) model[d] = int'($urandom_range(0, 4095)) - 2048;
    src_done = 1'b0;
    @(posedge clock); #1;
    capture_frame(nsat);
    src_done = 1'b0;
    wait_frame_end(cyc);
    check("t4_second_xfers", xfer_cnt, N);
    check("t4_second_sat", {16'd0, sat_count}, nsat);

    // Reset in the middle of a frame, then restart with the current image.
    for (int d = 0; d < N; d++) model[d] = (d * 7) % 1000;
    capture_frame(nsat);
    src_done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (xfer_cnt >= 700) break;
      @(posedge clock); #1;
    end
    check("t5_reached_700", {31'd0, xfer_cnt >= 700}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, m_valid}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_raw", {20'd0, m_raw}, 32'd0);
    check("t5_rst_sat", {16'd0, sat_count}, 32'd0);
    exp_q.delete();
    src_done = 1'b1;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    for (int d = 0; d < N; d++) model[d] = int'($urandom_range(0, 4095)) - 2048;
    capture_frame(nsat);
    src_done = 1'b0;
    wait_frame_end(cyc);
    check("t5_restart_xfers", xfer_cnt, N);
    check("t5_restart_sat", {16'd0, sat_count}, nsat);

    // Image changes right after capture must not leak into the frame.
    rand_ready = 1'b1;
    for (int d = 0; d < N; d++) model[d] = int'($urandom_range(0, 4095)) - 2048;
    capture_frame(nsat);
    for (int d = 0; d < N; d++) src_img[d*IN_W +: IN_W] = IN_W'($urandom);
    src_done = 1'b0;
    wait_frame_end(cyc);
    check("t6_xfers", xfer_cnt, N);
    check("t6_sat", {16'd0, sat_count}, nsat);
    rand_ready = 1'b0;

    // SHIFT=4 instance: shifted values fit, nothing saturates.
    m2[0] = 2047; m2[1] = -2048; m2[2] = -17; m2[3] = 291;
    nsat2 = 0;
    for (int k = 0; k < N2; k++) src_img2[k*IN_W +: IN_W] = IN_W'(m2[k]);
    m_ready2  = 1'b1;
    src_done2 = 1'b1;
    @(posedge clock); #1;
    src_done2 = 1'b0;
    for (int k = 0; k < N2; k++) begin
      v = ref_data(m2[k], 4, s);
      if (s) nsat2++;
      check("s4_valid", {31'd0, m_valid2}, 32'd1);
      check("s4_data", {24'd0, m_data2}, {24'd0, 8'(v)});
      check("s4_raw", {20'd0, m_raw2}, {20'd0, 12'(m2[k])});
      check("s4_last", {31'd0, m_last2}, {31'd0, k == N2 - 1});
      @(posedge clock); #1;
    end
    check("s4_end_valid", {31'd0, m_valid2}, 32'd0);
    check("s4_sat", {16'd0, sat_count2}, nsat2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
